// File: rtl/jtkcpu_stack_seq_pkg.sv
`default_nettype none
//==============================================================================
// Package  : jtkcpu_stack_seq_pkg
// Purpose  : Holds the mode codes, default frame masks and sequencer states
//            that the KCPU stack push/pull engine uses.
// Revision : 1.0 - initial release
//==============================================================================
package jtkcpu_stack_seq_pkg;

    localparam logic [1:0] c_stk_psh = 2'd0;
    localparam logic [1:0] c_stk_pul = 2'd1;
    localparam logic [1:0] c_stk_int = 2'd2;
    localparam logic [1:0] c_stk_rti = 2'd3;

    // bit0=CC ... bit7=PC; X, Y, U and PC are the 16-bit registers
    localparam logic [7:0] c_reg16    = 8'hF0;
    localparam logic [7:0] c_fullmsk  = 8'hFF;
    localparam logic [7:0] c_shortmsk = 8'h81;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PICK = 3'd1,
        ST_XFER = 3'd2,
        ST_CCRD = 3'd3,
        ST_FIN  = 3'd4
    } stk_state_t;

    function automatic logic stk_is_pull(input logic [1:0] mode);
        return (mode == c_stk_pul) || (mode == c_stk_rti);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtkcpu_stack_prio.sv
`default_nettype none
//==============================================================================
// Module   : jtkcpu_stack_prio
// Purpose  : Priority encoder over the pending register mask; msb_first picks
//            the highest set bit, otherwise the lowest set bit wins.
// Revision : 1.0 - initial release
//==============================================================================
module jtkcpu_stack_prio #(
    parameter int NREG = 8,
    localparam int SW  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic [NREG-1:0] req,
    input  logic            msb_first,
    output logic [SW-1:0]   idx,
    output logic            valid
);

    // Later loop iterations overwrite earlier ones, so the scan order sets priority
    always_comb begin
        idx   = '0;
        valid = |req;
        if (msb_first) begin
            for (int i = 0; i < NREG; i++) begin
                if (req[i]) idx = SW'(i);
            end
        end else begin
            for (int i = NREG - 1; i >= 0; i--) begin
                if (req[i]) idx = SW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtkcpu_stack_seq.sv
`default_nettype none
//==============================================================================
// Module   : jtkcpu_stack_seq
// Purpose  : Stack push/pull sequencer for PSHS/PSHU/PULS/PULU, interrupt
//            frames and RTI; one byte per memory access.
// Revision : 1.0 - initial release
//==============================================================================
module jtkcpu_stack_seq
    import jtkcpu_stack_seq_pkg::*;
#(
    parameter int              NREG     = 8,
    parameter int              AW       = 16,
    parameter logic [NREG-1:0] REG16    = NREG'(c_reg16),
    parameter logic [NREG-1:0] FULLMSK  = NREG'(c_fullmsk),
    parameter logic [NREG-1:0] SHORTMSK = NREG'(c_shortmsk),
    localparam int             SW       = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [NREG-1:0] mask,
    input  logic            efull,
    input  logic [AW-1:0]   sp_in,
    input  logic            mem_busy,
    input  logic [7:0]      rd_data,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   addr,
    output logic            we,
    output logic            rd,
    output logic [SW-1:0]   sel,
    output logic            hi,
    output logic            pul_en,
    output logic [AW-1:0]   sp_out,
    output logic            set_e
);

    stk_state_t      r_state,    w_state_nxt;
    logic [NREG-1:0] r_mask,     w_mask_nxt;
    logic [AW-1:0]   r_sp,       w_sp_nxt;
    logic [SW-1:0]   r_sel,      w_sel_nxt;
    logic            r_hi,       w_hi_nxt;
    logic            r_pull,     w_pull_nxt;
    logic            r_int_full, w_int_full_nxt;
    logic            r_rti,      w_rti_nxt;
    logic            r_cc_e,     w_cc_e_nxt;

    logic [NREG-1:0] w_start_mask;
    logic [NREG-1:0] w_rti_mask;
    logic [NREG-1:0] w_cur_bit;
    logic [NREG-1:0] w_enc_req;
    logic [SW-1:0]   w_enc_idx;
    logic            w_enc_vld;
    logic            w_is16;
    logic            w_last_byte;
    logic            w_xfer;
    logic            w_unused;

    assign w_unused = ^rd_data[6:0];

    always_comb begin
        w_start_mask = mask;
        case (mode)
            c_stk_int: w_start_mask = efull ? FULLMSK : SHORTMSK;
            c_stk_rti: w_start_mask = NREG'(1);
            default:   w_start_mask = mask;
        endcase
    end

    // CC has already been pulled when the RTI frame size becomes known
    assign w_rti_mask  = (r_cc_e ? FULLMSK : SHORTMSK) & ~NREG'(1);
    assign w_cur_bit   = NREG'(1) << r_sel;
    assign w_is16      = REG16[r_sel];
    // Push goes low byte then high byte, pull the reverse
    assign w_last_byte = !w_is16 || (r_hi != r_pull);
    assign w_xfer      = (r_state == ST_XFER);

    always_comb begin
        case (r_state)
            ST_XFER: w_enc_req = r_mask & ~w_cur_bit;
            ST_CCRD: w_enc_req = w_rti_mask;
            default: w_enc_req = r_mask;
        endcase
    end

    jtkcpu_stack_prio #(
        .NREG(NREG)
    ) u_prio (
        .req       (w_enc_req),
        .msb_first (!r_pull),
        .idx       (w_enc_idx),
        .valid     (w_enc_vld)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_mask_nxt     = r_mask;
        w_sp_nxt       = r_sp;
        w_sel_nxt      = r_sel;
        w_hi_nxt       = r_hi;
        w_pull_nxt     = r_pull;
        w_int_full_nxt = r_int_full;
        w_rti_nxt      = r_rti;
        w_cc_e_nxt     = r_cc_e;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt    = ST_PICK;
                    w_mask_nxt     = w_start_mask;
                    w_sp_nxt       = sp_in;
                    w_pull_nxt     = stk_is_pull(mode);
                    w_int_full_nxt = (mode == c_stk_int) && efull;
                    w_rti_nxt      = (mode == c_stk_rti);
                    w_cc_e_nxt     = 1'b0;
                end
            end
            ST_PICK, ST_CCRD: begin
                w_mask_nxt = w_enc_req;
                if (w_enc_vld) begin
                    w_state_nxt = ST_XFER;
                    w_sel_nxt   = w_enc_idx;
                    w_hi_nxt    = REG16[w_enc_idx] & r_pull;
                end else begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_XFER: begin
                if (!mem_busy) begin
                    w_sp_nxt = r_pull ? r_sp + AW'(1) : r_sp - AW'(1);
                    if (!w_last_byte) begin
                        w_hi_nxt = !r_hi;
                    end else begin
                        w_mask_nxt = w_enc_req;
                        if (r_rti && (r_sel == '0)) begin
                            w_cc_e_nxt  = rd_data[7];
                            w_state_nxt = ST_CCRD;
                        end else if (w_enc_vld) begin
                            // Decode the next register now so accesses run back to back
                            w_sel_nxt = w_enc_idx;
                            w_hi_nxt  = REG16[w_enc_idx] & r_pull;
                        end else begin
                            w_state_nxt = ST_FIN;
                        end
                    end
                end
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mask     <= '0;
            r_sp       <= '0;
            r_sel      <= '0;
            r_hi       <= 1'b0;
            r_pull     <= 1'b0;
            r_int_full <= 1'b0;
            r_rti      <= 1'b0;
            r_cc_e     <= 1'b0;
        end else if (cen) begin
            r_state    <= w_state_nxt;
            r_mask     <= w_mask_nxt;
            r_sp       <= w_sp_nxt;
            r_sel      <= w_sel_nxt;
            r_hi       <= w_hi_nxt;
            r_pull     <= w_pull_nxt;
            r_int_full <= w_int_full_nxt;
            r_rti      <= w_rti_nxt;
            r_cc_e     <= w_cc_e_nxt;
        end
    end

    always_comb begin
        busy   = (r_state == ST_PICK) || (r_state == ST_XFER) || (r_state == ST_CCRD);
        done   = (r_state == ST_FIN);
        we     = w_xfer && !r_pull;
        rd     = w_xfer && r_pull;
        addr   = '0;
        sel    = '0;
        hi     = 1'b0;
        if (w_xfer) begin
            addr = r_pull ? r_sp : r_sp - AW'(1);
            sel  = r_sel;
            hi   = r_hi;
        end
        // Strobes fire only on the cycle the access actually completes
        pul_en = rd && cen && !mem_busy;
        set_e  = we && r_int_full && (r_sel == '0) && cen && !mem_busy;
        sp_out = r_sp;
    end

endmodule
`default_nettype wire
